// File: rtl/latency_mem.sv
// Behavioural CPU-port memory with configurable read latency, in-order response
// queueing and response backpressure, used in place of cache/DRAM in testbenches.
module latency_mem #(
  parameter int CPU_WIDTH      = 32,
  parameter int WORD_ADDR_BITS = 30,
  parameter int MEM_DATA_BITS  = 128,
  parameter int DEPTH_LOG2     = 21,
  parameter int LATENCY        = 4,
  parameter int MAX_OUTSTAND   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req_valid,
  output logic                      cpu_req_ready,
  input  logic [WORD_ADDR_BITS-1:0] cpu_req_addr,
  input  logic [CPU_WIDTH-1:0]      cpu_req_data,
  input  logic [CPU_WIDTH/8-1:0]    cpu_req_write,
  output logic                      cpu_resp_valid,
  input  logic                      cpu_resp_ready,
  output logic [CPU_WIDTH-1:0]      cpu_resp_data
);

  localparam int WPL      = MEM_DATA_BITS / CPU_WIDTH;
  localparam int SEL_BITS = $clog2(WPL);
  localparam int SEL_W    = (SEL_BITS > 0) ? SEL_BITS : 1;
  localparam int BYTES    = CPU_WIDTH / 8;
  localparam int CNT_W    = $clog2(MAX_OUTSTAND + 1);
  localparam int PTR_W    = (MAX_OUTSTAND > 1) ? $clog2(MAX_OUTSTAND) : 1;
  localparam int AGE_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTAND);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LATENCY - 1);
  localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(MAX_OUTSTAND - 1);

  logic [MEM_DATA_BITS-1:0] mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] line;
  logic [SEL_W-1:0]      word_sel;
  logic [CPU_WIDTH-1:0]  rd_word;
  logic                  req_fire;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  pop;
  logic                  head_ready;
  logic                  unused_addr;

  // Each accepted read owns one slot from accept until pop. A slot's age counts
  // the edges since its push; the head becomes visible once it has aged LATENCY-1
  // edges, which is exactly the timing of a non-stalling LATENCY-stage pipeline.
  logic [CPU_WIDTH-1:0] fifo_data [MAX_OUTSTAND];
  logic [AGE_W-1:0]     fifo_age  [MAX_OUTSTAND];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     outstanding;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_TOP) ? '0 : p + PTR_W'(1);
  endfunction

  assign line        = cpu_req_addr[SEL_BITS +: DEPTH_LOG2];
  assign word_sel    = (SEL_BITS == 0) ? '0 : cpu_req_addr[SEL_W-1:0];
  assign unused_addr = ^cpu_req_addr;
  assign rd_word     = mem[line][int'(word_sel) * CPU_WIDTH +: CPU_WIDTH];

  assign cpu_req_ready = (outstanding < MAX_CNT);
  assign req_fire      = cpu_req_valid & cpu_req_ready & ~reset;
  assign rd_fire       = req_fire & (cpu_req_write == '0);
  assign wr_fire       = req_fire & (|cpu_req_write);

  assign head_ready     = (outstanding != '0) && (fifo_age[rd_ptr] == AGE_MAX);
  assign cpu_resp_valid = head_ready;
  assign cpu_resp_data  = head_ready ? fifo_data[rd_ptr] : '0;
  assign pop            = head_ready & cpu_resp_ready;

  // Byte-masked storage update; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < BYTES; b++) begin
        if (cpu_req_write[b]) begin
          mem[line][int'(word_sel) * CPU_WIDTH + b * 8 +: 8] <= cpu_req_data[b * 8 +: 8];
        end
      end
    end
  end

  // Capture read data at the accept edge and age every slot towards visibility.
  always_ff @(posedge clk) begin
    if (rd_fire) begin
      fifo_data[wr_ptr] <= rd_word;
    end
    for (int i = 0; i < MAX_OUTSTAND; i++) begin
      if (rd_fire && (wr_ptr == PTR_W'(i))) begin
        fifo_age[i] <= '0;
      end else if (fifo_age[i] != AGE_MAX) begin
        fifo_age[i] <= fifo_age[i] + AGE_W'(1);
      end
    end
  end

  // Queue pointers and outstanding credit; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (rd_fire) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({rd_fire, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_latency_mem.sv
// Self-checking bench for latency_mem: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a timestamped-queue model.
module tb_latency_mem;

  localparam int CW   = 32;
  localparam int AW   = 30;
  localparam int MDB  = 128;
  localparam int DL   = 12;
  localparam int LAT  = 3;
  localparam int MAXO = 4;
  localparam int SEL  = $clog2(MDB / CW);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req_valid = 1'b0;
  logic          cpu_req_ready;
  logic [AW-1:0] cpu_req_addr = '0;
  logic [CW-1:0] cpu_req_data = '0;
  logic [3:0]    cpu_req_write = 4'h0;
  logic          cpu_resp_valid;
  logic          cpu_resp_ready = 1'b0;
  logic [CW-1:0] cpu_resp_data;

  latency_mem #(
    .CPU_WIDTH(CW), .WORD_ADDR_BITS(AW), .MEM_DATA_BITS(MDB),
    .DEPTH_LOG2(DL), .LATENCY(LAT), .MAX_OUTSTAND(MAXO)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_req_write(cpu_req_write),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_ready(cpu_resp_ready),
    .cpu_resp_data(cpu_resp_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit checking = 1'b0;

  typedef struct { logic [31:0] data; int due; } pend_t;
  pend_t       pend_q[$];
  logic [31:0] mdl_mem [int unsigned];
  logic [31:0] got_d[$];
  int          got_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned mkey(input logic [AW-1:0] a);
    return int'(a) & ((1 << (DL + SEL)) - 1);
  endfunction

  function automatic logic [31:0] mdl_read(input logic [AW-1:0] a);
    int unsigned k = mkey(a);
    return mdl_mem.exists(k) ? mdl_mem[k] : 32'h0;
  endfunction

  // Model: every cycle compare outputs, then apply this cycle's handshakes.
  always @(negedge clk) begin
    logic        e_ready, e_valid;
    logic [31:0] e_data, w;
    cyc++;
    e_ready = (pend_q.size() < MAXO);
    e_valid = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    e_data  = e_valid ? pend_q[0].data : 32'h0;
    if (checking) begin
      check("req_ready", {31'h0, cpu_req_ready}, {31'h0, e_ready});
      check("resp_valid", {31'h0, cpu_resp_valid}, {31'h0, e_valid});
      check("resp_data", cpu_resp_data, e_data);
    end
    if (cpu_resp_valid && cpu_resp_ready && !reset) begin
      got_d.push_back(cpu_resp_data);
      got_c.push_back(cyc);
    end
    if (reset) begin
      pend_q.delete();
      checking = 1'b1;
    end else begin
      if (e_valid && cpu_resp_ready) void'(pend_q.pop_front());
      if (cpu_req_valid && e_ready) begin
        if (cpu_req_write == 4'h0) begin
          pend_q.push_back('{data: mdl_read(cpu_req_addr), due: cyc + LAT});
        end else begin
          w = mdl_read(cpu_req_addr);
          for (int b = 0; b < 4; b++)
            if (cpu_req_write[b]) w[b*8 +: 8] = cpu_req_data[b*8 +: 8];
          mdl_mem[mkey(cpu_req_addr)] = w;
        end
      end
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] we,
                      output int acc_cyc);
    acc_cyc = -1;
    @(posedge clk); #1;
    cpu_req_valid = 1'b1; cpu_req_addr = a; cpu_req_data = d; cpu_req_write = we;
    for (int n = 0; n < 100 && acc_cyc < 0; n++) begin
      @(negedge clk); #1;
      if (cpu_req_ready) acc_cyc = cyc;
    end
    if (acc_cyc < 0) begin
      errors++;
      $display("FAIL send_timeout: request @%h never accepted", a);
    end
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output int at_cyc);
    at_cyc = -1; d = 32'h0;
    for (int n = 0; n < 50 && at_cyc < 0; n++) begin
      @(negedge clk); #1;
      if (cpu_resp_valid) begin d = cpu_resp_data; at_cyc = cyc; end
    end
    if (at_cyc < 0) begin
      errors++;
      $display("FAIL resp_timeout: no response within 50 cycles");
    end
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 60 && got_d.size() < n; i++) @(negedge clk);
    #1;
    check("resp_count", got_d.size(), n);
  endtask

  initial begin
    int          ac, rc, acc, stalls, bad;
    logic [31:0] d;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    check("rst_ready", {31'h0, cpu_req_ready}, 32'h1);
    check("rst_valid", {31'h0, cpu_resp_valid}, 32'h0);
    check("rst_data", cpu_resp_data, 32'h0);
    cpu_resp_ready = 1'b1;

    // 1: write then read, exact latency, write gives no response
    got_d.delete();
    send(30'h10, 32'hDEADBEEF, 4'hF, ac);
    check("t1_no_wr_resp", got_d.size(), 0);
    send(30'h10, 32'h0, 4'h0, ac);
    wait_resp(d, rc);
    check("t1_data", d, 32'hDEADBEEF);
    check("t1_latency", rc - ac, LAT);

    // 2: byte masking and word select within a line
    send(30'h20, 32'h11223344, 4'hF, ac);
    send(30'h20, 32'hAABBCCDD, 4'b0101, ac);
    send(30'h20, 32'h0, 4'h0, ac);
    wait_resp(d, rc);
    check("t2_mask", d, 32'h11BB33DD);
    for (int i = 1; i < 4; i++) begin
      send(30'h20 + 30'(i), 32'h0, 4'h0, ac);
      wait_resp(d, rc);
      check("t2_word_sel", d, 32'h0);
    end

    // 3: backpressure limits reads in flight to MAXO
    for (int i = 0; i < 5; i++) send(30'h100 + 30'(i), 32'hA0000000 + i, 4'hF, ac);
    @(posedge clk); #1;
    cpu_resp_ready = 1'b0; got_d.delete(); acc = 0;
    cpu_req_valid = 1'b1; cpu_req_write = 4'h0; cpu_req_addr = 30'h100;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (cpu_req_ready) acc++;
      @(posedge clk); #1;
      cpu_req_addr = 30'h100 + 30'(acc);
    end
    check("t3_accepted", acc, 4);
    check("t3_ready_low", {31'h0, cpu_req_ready}, 32'h0);
    cpu_resp_ready = 1'b1;
    for (int n = 0; n < 20 && acc < 5; n++) begin
      @(negedge clk); #1;
      if (cpu_req_ready) acc++;
    end
    check("t3_fifth_acc", acc, 5);
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    wait_got(5);
    for (int i = 0; i < 5 && i < got_d.size(); i++) check("t3_order", got_d[i], 32'hA0000000 + i);

    // 4: full throughput with MAXO >= LAT+1
    for (int i = 0; i < 16; i++) send(30'h200 + 30'(i), 32'hB0000000 + i, 4'hF, ac);
    @(posedge clk); #1;
    got_d.delete(); got_c.delete(); stalls = 0;
    cpu_req_valid = 1'b1; cpu_req_write = 4'h0; cpu_req_addr = 30'h200;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      if (!cpu_req_ready) stalls++;
      @(posedge clk); #1;
      if (i < 15) cpu_req_addr = 30'h200 + 30'(i + 1);
      else cpu_req_valid = 1'b0;
    end
    check("t4_stalls", stalls, 0);
    wait_got(16);
    for (int i = 0; i < 16 && i < got_d.size(); i++) begin
      check("t4_data", got_d[i], 32'hB0000000 + i);
      if (i > 0) check("t4_consecutive", got_c[i] - got_c[i-1], 1);
    end

    // 5: reset drops in-flight reads, blocks a write, keeps memory
    send(30'h300, 32'h5A5A1234, 4'hF, ac);
    @(posedge clk); #1;
    got_d.delete();
    cpu_req_valid = 1'b1; cpu_req_write = 4'h0; cpu_req_addr = 30'h300;
    @(posedge clk); #1;
    cpu_req_addr = 30'h301;
    @(posedge clk); #1;
    reset = 1'b1; cpu_req_addr = 30'h300; cpu_req_write = 4'hF; cpu_req_data = 32'hFFFFFFFF;
    @(posedge clk); #1;
    reset = 1'b0; cpu_req_valid = 1'b0; cpu_req_write = 4'h0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (cpu_resp_valid) bad++;
    end
    check("t5_dropped", bad, 0);
    check("t5_ready", {31'h0, cpu_req_ready}, 32'h1);
    send(30'h300, 32'h0, 4'h0, ac);
    wait_resp(d, rc);
    check("t5_preserved", d, 32'h5A5A1234);

    // 6: aliasing beyond the storage depth
    send(30'h44, 32'hC0FFEE01, 4'hF, ac);
    send(30'h44 + 30'(1 << (DL + SEL)), 32'h0, 4'h0, ac);
    wait_resp(d, rc);
    check("t6_alias", d, 32'hC0FFEE01);

    // randomized traffic, occasional reset
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      reset          = ($urandom_range(0, 299) == 0);
      cpu_req_valid  = $urandom_range(0, 3) != 0;
      cpu_req_write  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      cpu_req_addr   = 30'($urandom_range(0, 63)) | (30'($urandom_range(0, 3)) << (DL + SEL));
      cpu_req_data   = $urandom;
      cpu_resp_ready = $urandom_range(0, 2) != 0;
    end
    @(posedge clk); #1;
    reset = 1'b0; cpu_req_valid = 1'b0; cpu_resp_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("drain_empty", pend_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
